// File: rtl/mcc_pkg.sv
// Shared definitions for the multi-cycle controller: state codes, opcodes,
// instruction classes and the datapath mux/ALU encodings.
// Imported by mcc_op_class and multi_cycle_ctrl.
package mcc_pkg;

   // State codes are visible on the State port, so they are fixed explicitly.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_WB_R     = 4'd7,
      S_EXEC_I   = 4'd8,
      S_WB_I     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11
   } stateT;

   // Instruction classes produced by the opcode decoder.
   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_LOAD    = 3'd1,
      CLS_STORE   = 3'd2,
      CLS_RTYPE   = 3'd3,
      CLS_ITYPE   = 3'd4,
      CLS_BRANCH  = 3'd5,
      CLS_JUMP    = 3'd6
   } opClassT;

   // Opcodes
   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_SLTIU  = 6'b001011;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   // ALUOp encodings
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNC   = 2'b10;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PCSrc encodings
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Successor of a memory-access state once the access completes.
   function automatic stateT memNextState(input stateT s);
      case (s)
         S_FETCH:  return S_DECODE;
         S_MEM_RD: return S_MEM_WB;
         default:  return S_FETCH;   // S_MEM_WR retires the store
      endcase
   endfunction

endpackage

// File: rtl/mcc_op_class.sv
// Combinational opcode-to-instruction-class decoder for the DECODE transitions.
// Ports: opCode (6-bit instruction opcode) -> opClass (3-bit opClassT code).
// Anything not explicitly recognised decodes to CLS_ILLEGAL.
module mcc_op_class
   import mcc_pkg::*;
(
   input  logic [5:0] opCode,
   output logic [2:0] opClass
);

   opClassT cls;

   always_comb begin
      cls = CLS_ILLEGAL;
      case (opCode)
         OP_LW:    cls = CLS_LOAD;
         OP_SW:    cls = CLS_STORE;
         OP_RTYPE: cls = CLS_RTYPE;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI:
                   cls = CLS_ITYPE;
         OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                   cls = CLS_BRANCH;
         OP_J:     cls = CLS_JUMP;
         default:  cls = CLS_ILLEGAL;
      endcase
   end

   assign opClass = cls;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM driving datapath mux selects and write strobes.
// Ports: clk/rst (sync, active-high), op_code, mem_ready in; datapath controls,
//   InstrDone, IllegalOp, MemTimeout and the 4-bit State code out.
// Build option MCC_MEM_WAIT_EN: memory states (FETCH, MEM_RD, MEM_WR) wait for
//   mem_ready, counting up to WAIT_MAX cycles before abandoning to FETCH with a
//   one-cycle MemTimeout pulse. Without it every memory state takes one cycle.
module multi_cycle_ctrl
   import mcc_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op_code,
   input  logic       mem_ready,
   output logic       PCWr,
   output logic       PCWrCond,
   output logic       IorD,
   output logic       MemRd,
   output logic       MemWr,
   output logic       IRWr,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic       RegDst,
   output logic       RegWr,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       InstrDone,
   output logic       IllegalOp,
   output logic       MemTimeout,
   output logic [3:0] State
);

   stateT      state;
   logic [3:0] waitCnt;
   logic       memTimeout;
   logic [2:0] opClassRaw;
   opClassT    opClass;
   logic       memDone;     // current memory access completes this cycle
   logic       memExpire;   // current memory access gives up this cycle

   mcc_op_class uOpClass (
      .opCode  (op_code),
      .opClass (opClassRaw)
   );

   assign opClass = opClassT'(opClassRaw);

`ifdef MCC_MEM_WAIT_EN
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

   assign memDone    = mem_ready;
   // waitCnt counts cycles already spent waiting, so the WAIT_MAX-th idle
   // cycle is the one where the counter reads WAIT_MAX-1.
   assign memExpire  = !mem_ready && (waitCnt == WAIT_LAST);
   assign MemTimeout = memTimeout && !rst;
`else
   logic [9:0] unusedNoWait;

   assign memDone      = 1'b1;
   assign memExpire    = 1'b0;
   assign MemTimeout   = 1'b0;
   assign unusedNoWait = {mem_ready, memTimeout, waitCnt, 4'(WAIT_MAX)};
`endif

   // State register, wait counter and the registered timeout pulse.
   // The counter defaults to zero so any state change clears it; it only
   // advances while a memory state is held waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_FETCH;
         waitCnt    <= '0;
         memTimeout <= 1'b0;
      end else begin
         waitCnt    <= '0;
         memTimeout <= 1'b0;
         case (state)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
               if (memDone) begin
                  state <= memNextState(state);
               end else if (memExpire) begin
                  state      <= S_FETCH;
                  memTimeout <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + 4'd1;
               end
            end
            S_DECODE: begin
               case (opClass)
                  CLS_LOAD, CLS_STORE: state <= S_MEM_ADDR;
                  CLS_RTYPE:           state <= S_EXEC_R;
                  CLS_ITYPE:           state <= S_EXEC_I;
                  CLS_BRANCH:          state <= S_BRANCH;
                  CLS_JUMP:            state <= S_JUMP;
                  default:             state <= S_FETCH;
               endcase
            end
            // op_code is still held, so LW/SW is re-decoded here.
            S_MEM_ADDR: state <= (opClass == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            S_EXEC_R:   state <= S_WB_R;
            S_EXEC_I:   state <= S_WB_I;
            default:    state <= S_FETCH;
         endcase
      end
   end

   // Control decode from the registered state. Everything is forced low while
   // rst is high so an aborted instruction never writes in the reset cycle.
   always_comb begin
      PCWr      = 1'b0;
      PCWrCond  = 1'b0;
      IorD      = 1'b0;
      MemRd     = 1'b0;
      MemWr     = 1'b0;
      IRWr      = 1'b0;
      MemtoReg  = 1'b0;
      ALUSrcA   = 1'b0;
      RegDst    = 1'b0;
      RegWr     = 1'b0;
      PCSrc     = PCSRC_ALU;
      ALUSrcB   = SRCB_REG;
      ALUOp     = ALUOP_ADD;
      InstrDone = 1'b0;
      IllegalOp = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               MemRd   = 1'b1;
               ALUSrcB = SRCB_FOUR;
               // IR and PC only latch on the cycle the fetch returns.
               IRWr    = memDone;
               PCWr    = memDone;
            end
            S_DECODE: begin
               ALUSrcB   = SRCB_IMM_SH2;
               IllegalOp = (opClass == CLS_ILLEGAL);
            end
            S_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
               MemRd = 1'b1;
               IorD  = 1'b1;
            end
            S_MEM_WB: begin
               MemtoReg  = 1'b1;
               RegWr     = 1'b1;
               InstrDone = 1'b1;
            end
            S_MEM_WR: begin
               MemWr     = 1'b1;
               IorD      = 1'b1;
               InstrDone = memDone;
            end
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNC;
            end
            S_WB_R: begin
               ALUSrcA   = 1'b1;
               ALUOp     = ALUOP_FUNC;
               RegDst    = 1'b1;
               RegWr     = 1'b1;
               InstrDone = 1'b1;
            end
            S_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_FUNC;
            end
            S_WB_I: begin
               ALUSrcA   = 1'b1;
               ALUSrcB   = SRCB_IMM;
               ALUOp     = ALUOP_FUNC;
               RegWr     = 1'b1;
               InstrDone = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA   = 1'b1;
               ALUOp     = ALUOP_BRANCH;
               PCWrCond  = 1'b1;
               PCSrc     = PCSRC_ALUOUT;
               InstrDone = 1'b1;
            end
            S_JUMP: begin
               PCWr      = 1'b1;
               PCSrc     = PCSRC_JUMP;
               InstrDone = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign State = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl: walks each instruction class cycle by
// cycle against hand-derived control words, plus reset and illegal-opcode cases.
// Wait/timeout scenarios run when MCC_MEM_WAIT_EN is defined.
module tb_multi_cycle_ctrl;
   import mcc_pkg::*;

   logic       clk;
   logic       rst;
   logic [5:0] op_code;
   logic       mem_ready;
   logic       PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, ALUSrcA, RegDst, RegWr;
   logic [1:0] PCSrc, ALUSrcB, ALUOp;
   logic       InstrDone, IllegalOp, MemTimeout;
   logic [3:0] State;

   int checks   = 0;
   int failures = 0;

   // Control word: {PCWr,PCWrCond,IorD,MemRd,MemWr,IRWr,MemtoReg,ALUSrcA,RegDst,RegWr,PCSrc,ALUSrcB,ALUOp}
   logic [15:0] ctl;
   logic [2:0]  stat;   // {InstrDone, IllegalOp, MemTimeout}
   assign ctl  = {PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, ALUSrcA,
                  RegDst, RegWr, PCSrc, ALUSrcB, ALUOp};
   assign stat = {InstrDone, IllegalOp, MemTimeout};

   // Hand-derived control words per state.
   localparam logic [15:0] C_FETCH  = 16'h9404;
   localparam logic [15:0] C_FWAIT  = 16'h1004;
   localparam logic [15:0] C_DECODE = 16'h000C;
   localparam logic [15:0] C_MADDR  = 16'h0108;
   localparam logic [15:0] C_MRD    = 16'h3000;
   localparam logic [15:0] C_MWB    = 16'h0240;
   localparam logic [15:0] C_MWR    = 16'h2800;
   localparam logic [15:0] C_EXR    = 16'h0102;
   localparam logic [15:0] C_WBR    = 16'h01C2;
   localparam logic [15:0] C_EXI    = 16'h010A;
   localparam logic [15:0] C_WBI    = 16'h014A;
   localparam logic [15:0] C_BR     = 16'h4111;
   localparam logic [15:0] C_JMP    = 16'h8020;

   multi_cycle_ctrl #(.WAIT_MAX(15)) dut (
      .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
      .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
      .IRWr(IRWr), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegDst(RegDst), .RegWr(RegWr),
      .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .InstrDone(InstrDone), .IllegalOp(IllegalOp), .MemTimeout(MemTimeout), .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; op_code = 6'b000000; mem_ready = 1'b1;
      tick(); tick();
      checks++;
      if (State !== S_FETCH || ctl !== 16'h0000 || stat !== 3'b000) begin
         failures++;
         $display("FAIL reset_hold: state=%0d ctl=%h stat=%b, expected state=0 ctl=0000 stat=000", State, ctl, stat);
      end
      rst = 1'b0; #1;
      checks++;
      if (State !== S_FETCH || ctl !== C_FETCH || stat !== 3'b000) begin
         failures++;
         $display("FAIL reset_release: state=%0d ctl=%h stat=%b, expected state=0 ctl=%h stat=000", State, ctl, stat, C_FETCH);
      end
   endtask

   task automatic test_rtype();
      logic [3:0]  st [4];
      logic [15:0] ct [4];
      logic [2:0]  ss [4];
      st = '{S_FETCH, S_DECODE, S_EXEC_R, S_WB_R};
      ct = '{C_FETCH, C_DECODE, C_EXR, C_WBR};
      ss = '{3'b000, 3'b000, 3'b000, 3'b100};
      op_code = OP_RTYPE;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (State !== st[i] || ctl !== ct[i] || stat !== ss[i]) begin
            failures++;
            $display("FAIL rtype cyc%0d: state=%0d ctl=%h stat=%b, expected state=%0d ctl=%h stat=%b", i + 1, State, ctl, stat, st[i], ct[i], ss[i]);
         end
         tick();
      end
      checks++;
      if (State !== S_FETCH) begin
         failures++;
         $display("FAIL rtype_return: state=%0d, expected 0", State);
      end
   endtask

   task automatic test_load();
      logic [3:0]  st [5];
      logic [15:0] ct [5];
      logic [2:0]  ss [5];
      st = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB};
      ct = '{C_FETCH, C_DECODE, C_MADDR, C_MRD, C_MWB};
      ss = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
      op_code = OP_LW;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (State !== st[i] || ctl !== ct[i] || stat !== ss[i]) begin
            failures++;
            $display("FAIL load cyc%0d (mem_ready=%b): state=%0d ctl=%h stat=%b, expected state=%0d ctl=%h stat=%b", i + 1, mem_ready, State, ctl, stat, st[i], ct[i], ss[i]);
         end
         tick();
      end
      checks++;
      if (State !== S_FETCH) begin
         failures++;
         $display("FAIL load_return: state=%0d, expected 0", State);
      end
   endtask

   task automatic test_store();
      logic [3:0]  st [4];
      logic [15:0] ct [4];
      logic [2:0]  ss [4];
      st = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR};
      ct = '{C_FETCH, C_DECODE, C_MADDR, C_MWR};
      ss = '{3'b000, 3'b000, 3'b000, 3'b100};
      op_code = OP_SW;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (State !== st[i] || ctl !== ct[i] || stat !== ss[i]) begin
            failures++;
            $display("FAIL store cyc%0d: state=%0d ctl=%h stat=%b, expected state=%0d ctl=%h stat=%b", i + 1, State, ctl, stat, st[i], ct[i], ss[i]);
         end
         tick();
      end
   endtask

   task automatic test_itype();
      logic [5:0]  ops [2];
      logic [3:0]  st [4];
      logic [15:0] ct [4];
      logic [2:0]  ss [4];
      ops = '{OP_ADDI, OP_XORI};
      st  = '{S_FETCH, S_DECODE, S_EXEC_I, S_WB_I};
      ct  = '{C_FETCH, C_DECODE, C_EXI, C_WBI};
      ss  = '{3'b000, 3'b000, 3'b000, 3'b100};
      for (int k = 0; k < 2; k++) begin
         op_code = ops[k];
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (State !== st[i] || ctl !== ct[i] || stat !== ss[i]) begin
               failures++;
               $display("FAIL itype op=%b cyc%0d: state=%0d ctl=%h stat=%b, expected state=%0d ctl=%h stat=%b", ops[k], i + 1, State, ctl, stat, st[i], ct[i], ss[i]);
            end
            tick();
         end
      end
   endtask

   task automatic test_branch_jump();
      logic [5:0]  ops [4];
      logic [3:0]  lastSt [4];
      logic [15:0] lastCt [4];
      ops    = '{OP_BEQ, OP_BGTZ, OP_REGIMM, OP_J};
      lastSt = '{S_BRANCH, S_BRANCH, S_BRANCH, S_JUMP};
      lastCt = '{C_BR, C_BR, C_BR, C_JMP};
      for (int k = 0; k < 4; k++) begin
         op_code = ops[k];
         checks++;
         if (State !== S_FETCH || ctl !== C_FETCH) begin
            failures++;
            $display("FAIL bj op=%b cyc1: state=%0d ctl=%h, expected state=0 ctl=%h", ops[k], State, ctl, C_FETCH);
         end
         tick();
         checks++;
         if (State !== S_DECODE || ctl !== C_DECODE || stat !== 3'b000) begin
            failures++;
            $display("FAIL bj op=%b cyc2: state=%0d ctl=%h stat=%b, expected state=1 ctl=%h stat=000", ops[k], State, ctl, stat, C_DECODE);
         end
         tick();
         checks++;
         if (State !== lastSt[k] || ctl !== lastCt[k] || stat !== 3'b100) begin
            failures++;
            $display("FAIL bj op=%b cyc3: state=%0d ctl=%h stat=%b, expected state=%0d ctl=%h stat=100", ops[k], State, ctl, stat, lastSt[k], lastCt[k]);
         end
         tick();
      end
   endtask

   task automatic test_illegal();
      logic [5:0] ops [3];
      ops = '{6'b111111, 6'b001111, 6'b000011};
      for (int k = 0; k < 3; k++) begin
         op_code = ops[k];
         tick();
         checks++;
         if (State !== S_DECODE || ctl !== C_DECODE || stat !== 3'b010) begin
            failures++;
            $display("FAIL illegal op=%b decode: state=%0d ctl=%h stat=%b, expected state=1 ctl=%h stat=010", ops[k], State, ctl, stat, C_DECODE);
         end
         tick();
         checks++;
         if (State !== S_FETCH || ctl !== C_FETCH || stat !== 3'b000) begin
            failures++;
            $display("FAIL illegal op=%b after: state=%0d ctl=%h stat=%b, expected state=0 ctl=%h stat=000", ops[k], State, ctl, stat, C_FETCH);
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [5:0] ops [4];
      int         depth [4];
      logic [3:0] st [4];
      ops   = '{OP_LW, OP_SW, OP_RTYPE, OP_J};
      depth = '{3, 3, 3, 2};
      st    = '{S_MEM_RD, S_MEM_WR, S_WB_R, S_JUMP};
      for (int k = 0; k < 4; k++) begin
         op_code = ops[k];
         for (int i = 0; i < depth[k]; i++) tick();
         checks++;
         if (State !== st[k]) begin
            failures++;
            $display("FAIL abort_reach op=%b: state=%0d, expected %0d", ops[k], State, st[k]);
         end
         rst = 1'b1; #1;
         checks++;
         if (ctl !== 16'h0000 || stat !== 3'b000) begin
            failures++;
            $display("FAIL abort_rst_cycle op=%b: ctl=%h stat=%b, expected ctl=0000 stat=000", ops[k], ctl, stat);
         end
         tick();
         checks++;
         if (State !== S_FETCH || ctl !== 16'h0000) begin
            failures++;
            $display("FAIL abort_after op=%b: state=%0d ctl=%h, expected state=0 ctl=0000", ops[k], State, ctl);
         end
         rst = 1'b0; #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [11];
      logic [3:0] st [11];
      logic       dn [11];
      ops = '{OP_J, OP_J, OP_J, OP_SW, OP_SW, OP_SW, OP_SW, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
      st  = '{S_FETCH, S_DECODE, S_JUMP, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR,
              S_FETCH, S_DECODE, S_EXEC_I, S_WB_I};
      dn  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 11; i++) begin
         op_code = ops[i];
         #1;
         checks++;
         if (State !== st[i] || InstrDone !== dn[i]) begin
            failures++;
            $display("FAIL b2b cyc%0d: state=%0d done=%b, expected state=%0d done=%b", i + 1, State, InstrDone, st[i], dn[i]);
         end
         tick();
      end
      checks++;
      if (State !== S_FETCH) begin
         failures++;
         $display("FAIL b2b_return: state=%0d, expected 0", State);
      end
   endtask

`ifdef MCC_MEM_WAIT_EN
   task automatic test_mem_wait();
      logic       rdy [7];
      logic [3:0] st [7];
      logic [15:0] ct [7];
      logic [2:0] ss [7];
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      st  = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_MEM_WR, S_MEM_WR, S_MEM_WR};
      ct  = '{C_FETCH, C_DECODE, C_MADDR, C_MWR, C_MWR, C_MWR, C_MWR};
      ss  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
      op_code = OP_SW;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rdy[i];
         #1;
         checks++;
         if (State !== st[i] || ctl !== ct[i] || stat !== ss[i]) begin
            failures++;
            $display("FAIL memwait cyc%0d: state=%0d ctl=%h stat=%b, expected state=%0d ctl=%h stat=%b", i + 1, State, ctl, stat, st[i], ct[i], ss[i]);
         end
         tick();
      end
      mem_ready = 1'b1; #1;
      checks++;
      if (State !== S_FETCH || ctl !== C_FETCH) begin
         failures++;
         $display("FAIL memwait_return: state=%0d ctl=%h, expected state=0 ctl=%h", State, ctl, C_FETCH);
      end
   endtask

   task automatic test_timeout();
      mem_ready = 1'b0; op_code = OP_J; #1;
      for (int i = 0; i < 15; i++) begin
         checks++;
         if (State !== S_FETCH || ctl !== C_FWAIT || stat !== 3'b000) begin
            failures++;
            $display("FAIL timeout_wait cyc%0d: state=%0d ctl=%h stat=%b, expected state=0 ctl=%h stat=000", i + 1, State, ctl, stat, C_FWAIT);
         end
         tick();
      end
      checks++;
      if (State !== S_FETCH || ctl !== C_FWAIT || stat !== 3'b001) begin
         failures++;
         $display("FAIL timeout_pulse: state=%0d ctl=%h stat=%b, expected state=0 ctl=%h stat=001", State, ctl, stat, C_FWAIT);
      end
      tick();
      checks++;
      if (State !== S_FETCH || stat !== 3'b000) begin
         failures++;
         $display("FAIL timeout_clear: state=%0d stat=%b, expected state=0 stat=000", State, stat);
      end
      mem_ready = 1'b1; #1;
      checks++;
      if (ctl !== C_FETCH) begin
         failures++;
         $display("FAIL timeout_resume: ctl=%h, expected %h", ctl, C_FETCH);
      end
      tick(); tick(); tick();
      checks++;
      if (State !== S_FETCH) begin
         failures++;
         $display("FAIL timeout_jump_return: state=%0d, expected 0", State);
      end
   endtask
`else
   // mem_ready must have no effect: LW still takes 5 cycles with it held low.
   task automatic test_ready_ignored();
      mem_ready = 1'b0;
      test_load();
      checks++;
      if (MemTimeout !== 1'b0 || ctl !== C_FETCH) begin
         failures++;
         $display("FAIL ready_ignored: MemTimeout=%b ctl=%h, expected 0 and %h", MemTimeout, ctl, C_FETCH);
      end
      mem_ready = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_rtype();
      test_load();
      test_store();
      test_itype();
      test_branch_jump();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
`ifdef MCC_MEM_WAIT_EN
      test_mem_wait();
      test_timeout();
`else
      test_ready_ignored();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of memory wait cycles per access before timeout (used only when MCC_MEM_WAIT_EN is defined).
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port op_code  input  6  instruction opcode, valid from the DECODE state onward.
REQ-005 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-006 SHALL have outputs PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, MemtoReg, ALUSrcA, RegDst, RegWr, each 1 bit, as datapath controls.
REQ-007 SHALL have outputs PCSrc (2 bits: 00 ALU, 01 ALUOut, 10 jump target), ALUSrcB (2 bits: 00 reg, 01 const 4, 10 sign-extended immediate, 11 immediate<<2) and ALUOp (2 bits: 00 add, 01 branch compare, 10 function/opcode decode).
REQ-008 SHALL have outputs InstrDone (1 bit), IllegalOp (1 bit), MemTimeout (1 bit) and State (4 bits, current state code).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH and JUMP; every control output not listed for a state SHALL be 0.
REQ-010 FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, with IRWr=1 and PCWr=1 only in the completing cycle; the FSM SHALL then go to DECODE.
REQ-011 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state SHALL be chosen by op_code.
- LW 100011 or SW 101011 -> MEM_ADDR.
- 000000 -> EXEC_R.
- ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI (001000-001110) -> EXEC_I.
- BEQ/BNE/BLEZ/BGTZ (000100-000111) or REGIMM 000001 -> BRANCH.
- J 000010 -> JUMP.
- Any other opcode -> FETCH, with IllegalOp=1 for that DECODE cycle.
REQ-012 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state SHALL be MEM_RD for LW and MEM_WR for SW.
REQ-013 MEM_RD: MemRd=1, IorD=1; completes to MEM_WB.
REQ-014 MEM_WB: RegDst=0, MemtoReg=1, RegWr=1; next state FETCH.
REQ-015 MEM_WR: MemWr=1, IorD=1; completes to FETCH.
REQ-016 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state WB_R.
REQ-017 WB_R: RegDst=1, RegWr=1 and the EXEC_R ALU controls held; next state FETCH.
REQ-018 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=10; next state WB_I.
REQ-019 WB_I: RegDst=0, RegWr=1 and the EXEC_I ALU controls held; next state FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWrCond=1, PCSrc=01; next state FETCH.
REQ-021 JUMP: PCWr=1, PCSrc=10; next state FETCH.
REQ-022 InstrDone SHALL pulse for one cycle in the last state of each instruction (MEM_WB, MEM_WR completion, WB_R, WB_I, BRANCH, JUMP).
REQ-023 Cycle counts with zero wait SHALL be: LW 5, SW/R/I 4, branch/J 3.

Reset
REQ-024 While rst=1 the FSM SHALL enter FETCH on the next edge, with all control outputs, InstrDone, IllegalOp, MemTimeout and the wait counter at 0; FETCH outputs SHALL become active in the first cycle after rst falls.
REQ-025 A reset during any state, including a memory wait, SHALL abort the instruction with no PCWr, RegWr or MemWr in the reset cycle.

Configuration
REQ-026 With MCC_MEM_WAIT_EN defined, FETCH, MEM_RD and MEM_WR SHALL complete only in a cycle with mem_ready=1.
- While waiting, the state's outputs SHALL be held and a 4-bit wait counter SHALL increment.
- After WAIT_MAX cycles without mem_ready, the FSM SHALL assert MemTimeout for one cycle and go to FETCH without writes.
- The counter SHALL clear on every state change.
REQ-027 Without MCC_MEM_WAIT_EN, each memory state SHALL complete in one cycle, mem_ready SHALL be ignored, and MemTimeout SHALL be tied to 0.

Structure
REQ-028 The state enum (4-bit codes), the opcode constants and the ALUOp/ALUSrcB/PCSrc encodings SHALL live in the shared package mcc_pkg.
REQ-029 A single sub-module, mcc_op_class, SHALL be used as the combinational opcode-to-instruction-class decoder feeding the DECODE transitions.

Verification
REQ-030 Reset, then op_code=000000 -> sequence FETCH, DECODE, EXEC_R, WB_R; RegDst=1 and RegWr=1 in cycle 4; InstrDone in cycle 4.
REQ-031 op_code=100011 with zero wait -> 5 states ending in MEM_WB with MemtoReg=1 and RegWr=1.
REQ-032 op_code=101011 with MCC_MEM_WAIT_EN defined and mem_ready low for 3 cycles in MEM_WR -> MemWr held for 4 cycles, then FETCH.
REQ-033 op_code=000100 -> PCWrCond=1 and PCSrc=01 in cycle 3; op_code=000010 -> PCWr=1 and PCSrc=10 in cycle 3.
REQ-034 op_code=111111 -> IllegalOp=1 in DECODE, then FETCH, with no RegWr or MemWr.
REQ-035 With MCC_MEM_WAIT_EN defined and mem_ready stuck at 0 in FETCH -> MemTimeout after 15 cycles; separately, rst asserted mid-MEM_RD -> FETCH with all writes 0.
